// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared state codes, state width and default tick rate for the stopwatch controller.
package cronometro_pkg;
    localparam int STATE_W = 2;
    localparam int TICK_HZ_DEF = 100;
    typedef enum logic [STATE_W-1:0] {
        PARADO    = 2'd0,
        CORRIENDO = 2'd1,
        PAUSA     = 2'd2,
        VUELTA    = 2'd3
    } estado_t;
endpackage

// File: rtl/control_cronometro_if.sv
// control_cronometro_if: front-panel buttons, digit-chain status and controller outputs.
interface control_cronometro_if;
    import cronometro_pkg::*;
    logic btn_start;
    logic btn_lap;
    logic max_reached;
    logic tick;
    logic clr;
    logic run;
    logic hold;
    logic [STATE_W-1:0] estado;
    modport master (output btn_start, btn_lap, max_reached, input tick, clr, run, hold, estado);
    modport slave (input btn_start, btn_lap, max_reached, output tick, clr, run, hold, estado);
endinterface

// File: rtl/antirrebote.sv
// antirrebote: 2-flop synchronizer, stability counter and one-cycle press pulse on the accepted rising edge.
module antirrebote #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic level;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/control_cronometro.sv
// control_cronometro: run/pause/lap FSM and 100 Hz prescaler for the stopwatch digit chain.
// Define CRONO_LAP_EN to enable the VUELTA (lap hold) state.
module control_cronometro
    import cronometro_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = TICK_HZ_DEF,
    parameter int DB_CYCLES = 1_000_000
) (
    input logic clk,
    input logic rst,
    control_cronometro_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    estado_t st, nxt;
    logic [PW-1:0] cnt;
    logic start_ev, lap_ev, due, nxt_run, nxt_clr;
    logic tick_q, clr_q, run_q;
    antirrebote #(.DB_CYCLES(DB_CYCLES)) u_start (.clk(clk), .rst(rst), .btn(bus.btn_start), .press(start_ev));
    antirrebote #(.DB_CYCLES(DB_CYCLES)) u_lap (.clk(clk), .rst(rst), .btn(bus.btn_lap), .press(lap_ev));
    // start wins over lap in every state; saturation overrides any button
    always_comb begin
        nxt = st;
        nxt_clr = 1'b0;
        due = run_q && cnt == PW'(DIV - 1);
        case (st)
            PARADO: begin
                nxt = start_ev ? CORRIENDO : PARADO;
                nxt_clr = lap_ev && !start_ev;
            end
`ifdef CRONO_LAP_EN
            CORRIENDO: nxt = start_ev ? PAUSA : lap_ev ? VUELTA : CORRIENDO;
            VUELTA: nxt = start_ev ? PAUSA : lap_ev ? CORRIENDO : VUELTA;
`else
            CORRIENDO: nxt = start_ev ? PAUSA : CORRIENDO;
`endif
            PAUSA: begin
                nxt = start_ev ? CORRIENDO : lap_ev ? PARADO : PAUSA;
                nxt_clr = lap_ev && !start_ev;
            end
            default: nxt = PARADO;
        endcase
        if (due && bus.max_reached) nxt = PAUSA;
        nxt_run = nxt == CORRIENDO || nxt == VUELTA;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= PARADO;
            cnt    <= '0;
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            st     <= nxt;
            cnt    <= (nxt == PARADO || due) ? '0 : run_q ? cnt + PW'(1) : cnt;
            tick_q <= due && !bus.max_reached && nxt_run;
            clr_q  <= nxt_clr;
            run_q  <= nxt_run;
        end
    end
    assign bus.tick = tick_q;
    assign bus.clr = clr_q;
    assign bus.run = run_q;
    assign bus.estado = st;
`ifdef CRONO_LAP_EN
    logic hold_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= 1'b0;
        else hold_q <= nxt == VUELTA;
    end
    assign bus.hold = hold_q;
`else
    assign bus.hold = 1'b0;
`endif
endmodule

// File: tb/tb_control_cronometro.sv
// tb_control_cronometro: directed checks of control_cronometro with DIV=4, DB_CYCLES=3.
module tb_control_cronometro;
    import cronometro_pkg::*;
`ifdef CRONO_LAP_EN
    localparam int VU = 3;
`else
    localparam int VU = 1;
`endif
    typedef struct {
        int s;
        int l;
        int est;
        int c;
    } op_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    op_t ops[14];
    control_cronometro_if bus();
    control_cronometro #(.CLK_HZ(4), .TICK_HZ(1), .DB_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // packed as {tick, clr, run, hold, estado[1:0]}
    function automatic int expect_out(int tick, int clr, int est);
        return (tick << 5) | (clr << 4) | (int'(est == 1 || est == 3) << 3) | (int'(est == 3) << 2) | est;
    endfunction

    function automatic int got_out();
        return int'({bus.tick, bus.clr, bus.run, bus.hold, bus.estado});
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (tick,clr,run,hold,estado) at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sch_start(int k);
        return (k < 6) || (k >= 18 && k < 24) || (k >= 31 && k < 37) || (k >= 48 && k < 54) || (k >= 72 && k < 78);
    endfunction

    function automatic logic sch_lap(int k);
        return (k >= 60 && k < 66) || (k >= 88 && k < 94) || (k >= 100 && k < 106);
    endfunction

    function automatic logic sch_max(int k);
        return k >= 112 && k < 118;
    endfunction

    function automatic int exp_est(int k);
        if (k < 6) return 0;
        if (k < 24) return 1;
        if (k < 37) return 2;
        if (k < 54) return 1;
        if (k < 66) return 2;
        if (k < 78) return 0;
        if (k < 94) return 1;
        if (k < 106) return VU;
        if (k < 114) return 1;
        return 2;
    endfunction

    function automatic int is_tick(int k);
        return int'(k inside {10, 14, 18, 22, 39, 43, 47, 51, 82, 86, 90, 94, 98, 102, 106, 110});
    endfunction

    initial begin
        ops = '{
            '{1, 0, 1, 0}, '{1, 0, 2, 0}, '{1, 0, 1, 0}, '{0, 1, VU, 0}, '{0, 1, 1, 0},
            '{0, 1, VU, 0}, '{1, 0, 2, 0}, '{0, 1, 0, 1}, '{0, 1, 0, 1}, '{1, 1, 1, 0},
            '{1, 1, 2, 0}, '{1, 0, 1, 0}, '{1, 0, 2, 0}, '{0, 1, 0, 1}
        };
        bus.btn_start = 1'b0;
        bus.btn_lap = 1'b0;
        bus.max_reached = 1'b0;
        repeat (3) step();
        chk("reset_held", got_out(), 0);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("idle%0d", i), got_out(), 0);
        end
        // two-cycle glitch must never be accepted
        bus.btn_start = 1'b1;
        repeat (2) step();
        bus.btn_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("glitch%0d", i), got_out(), 0);
        end
        for (int i = 0; i < 14; i++) begin
            bus.btn_start = ops[i].s != 0;
            bus.btn_lap = ops[i].l != 0;
            repeat (6) step();
            chk($sformatf("op%0d_enter", i), got_out() & 'h1f, expect_out(0, ops[i].c, ops[i].est));
            bus.btn_start = 1'b0;
            bus.btn_lap = 1'b0;
            step();
            chk($sformatf("op%0d_after", i), got_out() & 'h1f, expect_out(0, 0, ops[i].est));
            repeat (5) step();
        end
        // cycle-exact run: prescaler phase, pause retention, clear, lap, saturation
        for (int k = 0; k <= 120; k++) begin
            chk($sformatf("seq_k%0d", k), got_out(), expect_out(is_tick(k), int'(k == 66), exp_est(k)));
            bus.btn_start = sch_start(k);
            bus.btn_lap = sch_lap(k);
            bus.max_reached = sch_max(k);
            step();
        end
        bus.btn_start = 1'b0;
        bus.btn_lap = 1'b0;
        bus.max_reached = 1'b0;
        chk("pre_async", got_out(), expect_out(0, 0, 2));
        #2 rst = 1'b0;
        #1 chk("async_reset", got_out(), 0);
        step();
        chk("reset_no_clr", got_out(), 0);
        rst = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
